pe_issue_ctrl: RTL

//  Per-PE instruction sequencer. It sits directly upstream of the PE multiply-add unit.
//  - Fetches instructions from the PE instruction ROM and reads three operands from PE data memory.
//  - Issues a, b, c and subtract to the multiply-add unit.
//  - Writes the unit's result p back to data memory, MULADD_LAT cycles after issue.
//  - Detects read-after-write hazards on in-flight destinations and stalls issue until they clear.

---
 rtl/pe_issue_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_issue_ctrl.sv
// pe_issue_ctrl
//   Per-PE instruction sequencer feeding a multiply-add unit. It fetches
//   {op,dst,srcA,srcB,srcC} words from the instruction ROM, reads three
//   operands from data memory and issues them with an add/subtract select.
//   The unit's result is written back MULADD_LAT cycles after issue.
//   A decoded op that reads a register still in flight is held in decode
//   until that write has landed.
//
//   Pipeline: F (inst_addr=pc) -> D (decode, rd_addr) -> R (operands
//             registered) -> I (issue_valid) -> W (wr_en, MULADD_LAT after I)
//
// Ports
//   clk, Resetn          clock, synchronous active-low reset
//   start / busy / done  run control and status
//   inst_addr/inst_rdata instruction ROM port (1-cycle read)
//   rd_addr_*/rd_data_*  three data-memory read ports (1-cycle read)
//   a, b, c, subtract    operands and mode for the multiply-add unit
//   issue_valid          a/b/c/subtract carry a real operation this cycle
//   p_in                 multiply-add result
//   wr_en/wr_addr/wr_data data-memory write port (wr_data = p_in)
`timescale 1ns/1ps
module pe_issue_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 8,
  parameter int PWIDTH     = 10,
  parameter int MULADD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  Resetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [PWIDTH-1:0]     inst_addr,
  input  logic [2+4*AWIDTH-1:0] inst_rdata,
  output logic [AWIDTH-1:0]     rd_addr_a,
  output logic [AWIDTH-1:0]     rd_addr_b,
  output logic [AWIDTH-1:0]     rd_addr_c,
  input  logic [DWIDTH-1:0]     rd_data_a,
  input  logic [DWIDTH-1:0]     rd_data_b,
  input  logic [DWIDTH-1:0]     rd_data_c,
  output logic [DWIDTH-1:0]     a,
  output logic [DWIDTH-1:0]     b,
  output logic [DWIDTH-1:0]     c,
  output logic                  subtract,
  output logic                  issue_valid,
  input  logic [DWIDTH-1:0]     p_in,
  output logic                  wr_en,
  output logic [AWIDTH-1:0]     wr_addr,
  output logic [DWIDTH-1:0]     wr_data
);

  localparam int IWIDTH = 2 + 4*AWIDTH;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;
  localparam logic [PWIDTH-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state;
  logic [PWIDTH-1:0]   pc;

  // Decode stage. While held, the instruction lives in hold_inst because
  // the ROM output has already moved on to the next word.
  logic                d_valid;
  logic                d_force_end;   // fetch slot at PC_MAX acts as END
  logic                d_held;
  logic [IWIDTH-1:0]   hold_inst;

  // Operand-read stage
  logic                r_valid;
  logic [AWIDTH-1:0]   r_dst;
  logic                r_sub;

  // Issue-to-writeback delay line: index 0 is the issue cycle,
  // index MULADD_LAT is the write-back cycle.
  logic                vld   [0:MULADD_LAT];
  logic [AWIDTH-1:0]   dst_q [0:MULADD_LAT];

  logic [IWIDTH-1:0]   d_inst;
  logic [1:0]          d_op;
  logic [AWIDTH-1:0]   d_dst, src_a, src_b, src_c;
  logic                d_is_end, d_is_op, hazard, stall, fetch, any_pending;

  assign d_inst   = d_held ? hold_inst : inst_rdata;
  assign d_op     = d_inst[IWIDTH-1 -: 2];
  assign d_dst    = d_inst[4*AWIDTH-1 -: AWIDTH];
  assign src_a    = d_inst[3*AWIDTH-1 -: AWIDTH];
  assign src_b    = d_inst[2*AWIDTH-1 -: AWIDTH];
  assign src_c    = d_inst[AWIDTH-1:0];

  assign d_is_end = d_valid && (d_force_end || d_op == OP_END);
  assign d_is_op  = d_valid && !d_force_end && (d_op == OP_ADD || d_op == OP_SUB);

  // NOTE: every always_comb output gets a default before any condition,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    hazard      = 1'b0;
    any_pending = r_valid;
    if (r_valid && (r_dst == src_a || r_dst == src_b || r_dst == src_c))
      hazard = 1'b1;
    for (int k = 0; k <= MULADD_LAT; k++) begin
      any_pending = any_pending | vld[k];
      if (vld[k] && (dst_q[k] == src_a || dst_q[k] == src_b || dst_q[k] == src_c))
        hazard = 1'b1;
    end
  end

  assign stall = d_is_op && hazard;
  assign fetch = (state == S_RUN) && !stall && !d_is_end;

  assign inst_addr   = pc;
  assign rd_addr_a   = d_valid ? src_a : '0;
  assign rd_addr_b   = d_valid ? src_b : '0;
  assign rd_addr_c   = d_valid ? src_c : '0;
  assign issue_valid = vld[0];
  assign wr_en       = vld[MULADD_LAT];
  assign wr_addr     = dst_q[MULADD_LAT];
  assign wr_data     = p_in;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      d_valid     <= 1'b0;
      d_force_end <= 1'b0;
      d_held      <= 1'b0;
      hold_inst   <= '0;
      r_valid     <= 1'b0;
      r_dst       <= '0;
      r_sub       <= 1'b0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      subtract    <= 1'b0;
      // NOTE: the delay line is a handful of flops, not a RAM; it is reset
      // so in-flight results can never raise wr_en after a reset.
      for (int k = 0; k <= MULADD_LAT; k++) begin
        vld[k]   <= 1'b0;
        dst_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          pc    <= '0;
          busy  <= 1'b1;
        end
        S_RUN:   if (d_is_end) state <= S_DRAIN;
        S_DRAIN: if (!any_pending) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // Fetch / decode. A stalled decode keeps d_valid and pc unchanged.
      if (fetch) begin
        d_valid     <= 1'b1;
        d_force_end <= (pc == PC_MAX);
        if (pc != PC_MAX) pc <= pc + 1'b1;
      end else if (!stall) begin
        d_valid     <= 1'b0;
        d_force_end <= 1'b0;
      end
      d_held <= stall;
      if (stall) hold_inst <= d_inst;

      // Operand read: rd_data arrives this cycle for last cycle's decode.
      r_valid <= d_is_op && !stall && (state == S_RUN);
      r_dst   <= d_dst;
      r_sub   <= (d_op == OP_SUB);

      // Issue; operands hold their last value when nothing issues.
      vld[0]   <= r_valid;
      dst_q[0] <= r_dst;
      if (r_valid) begin
        a        <= rd_data_a;
        b        <= rd_data_b;
        c        <= rd_data_c;
        subtract <= r_sub;
      end
      for (int k = 1; k <= MULADD_LAT; k++) begin
        vld[k]   <= vld[k-1];
        dst_q[k] <= dst_q[k-1];
      end
    end
  end

  // NOP carries no fields that matter; named here so the opcode map reads
  // complete next to the decode above.
  logic unused_nop;
  assign unused_nop = (d_op == OP_NOP);

endmodule
